// File: rtl/ascon_pkg.sv
// -----------------------------------------------------------------------------
// ascon_pkg
// Shared types and constants for the iterative Ascon-p permutation engine.
//   state_t      : 320-bit state as five 64-bit lanes, x0 = state[0].
//   fsm_t        : controller states of the permutation engine.
//   round_const  : round constant for round index r (0..11 -> 0xF0..0x4B).
//   ROT_A/ROT_B  : per-lane rotate-right amounts of the linear layer.
//   ror64        : 64-bit rotate right by a constant amount.
// -----------------------------------------------------------------------------
package ascon_pkg;

    typedef logic [4:0][63:0] state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    localparam int ASCON_MAX_ROUNDS = 12;

    // Linear layer: x_i ^= ror(x_i, ROT_A[i]) ^ ror(x_i, ROT_B[i])
    localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

    // Upper nibble counts down while the lower nibble counts up.
    function automatic logic [7:0] round_const(input logic [3:0] r);
        return {4'hF - r, r};
    endfunction

    // Only ever called with constant amounts in 1..63, so both shifts are real.
    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned amt);
        return (x >> amt) | (x << (64 - amt));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// -----------------------------------------------------------------------------
// ascon_round
// One combinational Ascon-p round: constant addition, bitsliced 5-bit S-box,
// and the per-lane linear diffusion layer.
// Ports:
//   state_i  in  320  state entering the round (x0 = state_i[0])
//   rc_i     in  8    round constant, XORed into the low byte of x2
//   state_o  out 320  state after the round
// -----------------------------------------------------------------------------
module ascon_round
    import ascon_pkg::*;
(
    input  logic [4:0][63:0] state_i,
    input  logic [7:0]       rc_i,
    output logic [4:0][63:0] state_o
);

    state_t x;
    state_t t;

    always_comb begin
        // NOTE: every variable written here gets a value first, so no path
        // leaves it holding an old value and no latch is inferred.
        x       = state_i;
        t       = '0;
        state_o = '0;

        // NOTE: blocking assignments are deliberate in combinational logic:
        // each S-box step must see the result of the step before it.
        x[2] = x[2] ^ {56'b0, rc_i};

        // S-box, bitsliced across all 64 columns at once
        x[0] = x[0] ^ x[4];
        x[4] = x[4] ^ x[3];
        x[2] = x[2] ^ x[1];
        for (int i = 0; i < 5; i++) begin
            t[i] = ~x[i] & x[(i + 1) % 5];
        end
        for (int i = 0; i < 5; i++) begin
            x[i] = x[i] ^ t[(i + 1) % 5];
        end
        x[1] = x[1] ^ x[0];
        x[0] = x[0] ^ x[4];
        x[3] = x[3] ^ x[2];
        x[2] = ~x[2];

        // Linear layer
        for (int i = 0; i < 5; i++) begin
            state_o[i] = x[i] ^ ror64(x[i], ROT_A[i]) ^ ror64(x[i], ROT_B[i]);
        end
    end

endmodule

// File: rtl/ascon_perm.sv
// -----------------------------------------------------------------------------
// ascon_perm
// Iterative Ascon-p permutation: one round per clock on a 320-bit state.
// A start in IDLE loads state_i and the clamped round count n; the engine then
// runs rounds MAX_ROUNDS-n .. MAX_ROUNDS-1 and pulses done_o for one cycle.
// Ports:
//   clk_i     in  1        clock
//   rst_n_i   in  1        asynchronous active-low reset
//   start_i   in  1        request a permutation (sampled only in IDLE)
//   rounds_i  in  RND_W    number of rounds, clamped to MAX_ROUNDS
//   state_i   in  320      input state, x0 = state_i[0]
//   state_o   out 320      working/result state register
//   busy_o    out 1        rounds in progress
//   done_o    out 1        one-cycle completion pulse, state_o valid
//   ready_o   out 1        idle; a start will be accepted
// -----------------------------------------------------------------------------
module ascon_perm
    import ascon_pkg::*;
#(
    parameter int MAX_ROUNDS = ASCON_MAX_ROUNDS,
    // The round counter must be able to hold MAX_ROUNDS itself.
    parameter int RND_W      = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [RND_W-1:0] rounds_i,
    input  logic [4:0][63:0] state_i,
    output logic [4:0][63:0] state_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             ready_o
);

    localparam logic [RND_W-1:0] MAX_R  = RND_W'(MAX_ROUNDS);
    localparam logic [RND_W-1:0] LAST_R = RND_W'(MAX_ROUNDS - 1);

    fsm_t             fsm_q, fsm_d;
    logic [RND_W-1:0] rnd_q, rnd_d;
    logic [RND_W-1:0] n_rounds;
    state_t           st_q, st_d;
    state_t           round_out;

    ascon_round u_round (
        .state_i (st_q),
        .rc_i    (round_const(4'(rnd_q))),
        .state_o (round_out)
    );

    always_comb begin
        fsm_d    = fsm_q;
        rnd_d    = rnd_q;
        st_d     = st_q;
        n_rounds = (rounds_i > MAX_R) ? MAX_R : rounds_i;

        case (fsm_q)
            IDLE: begin
                if (start_i) begin
                    st_d  = state_i;
                    // Starting index so that the last round run is always MAX_ROUNDS-1.
                    rnd_d = MAX_R - n_rounds;
                    fsm_d = (n_rounds == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                st_d  = round_out;
                rnd_d = rnd_q + RND_W'(1);
                if (rnd_q == LAST_R) begin
                    fsm_d = DONE;
                end
            end
            DONE:    fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase

        // Moore outputs straight from the state register: reset forces them at once.
        ready_o = (fsm_q == IDLE);
        busy_o  = (fsm_q == RUN);
        done_o  = (fsm_q == DONE);
        state_o = st_q;
    end

    // NOTE: the wide state register is reset too, so state_o reads zero out of
    // reset rather than whatever the flops powered up with.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fsm_q <= IDLE;
            rnd_q <= '0;
            st_q  <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            fsm_q <= fsm_d;
            rnd_q <= rnd_d;
            st_q  <= st_d;
        end
    end

endmodule

// File: tb/tb_ascon_perm.sv
// -----------------------------------------------------------------------------
// tb_ascon_perm
// Self-checking bench for ascon_perm. The stimulus process issues requests and
// pushes the expected result, round count and accept cycle into a scoreboard;
// a separate monitor pops an entry on every done_o pulse and compares.
// Expected states come from hand-derived constants (single round on zero state)
// and from a table-driven S-box reference model.
// -----------------------------------------------------------------------------
module tb_ascon_perm;
    import ascon_pkg::*;

    logic       clk_i;
    logic       rst_n_i;
    logic       start_i;
    logic [3:0] rounds_i;
    state_t     state_i;
    state_t     state_o;
    logic       busy_o;
    logic       done_o;
    logic       ready_o;

    ascon_perm #(.MAX_ROUNDS(12), .RND_W(4)) dut (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .start_i  (start_i),
        .rounds_i (rounds_i),
        .state_i  (state_i),
        .state_o  (state_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .ready_o  (ready_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Ascon 5-bit S-box, index = {x0,x1,x2,x3,x4} column bits
    logic [4:0] sbox_tbl [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    function automatic logic [63:0] rotr(input logic [63:0] v, input int k);
        logic [127:0] d;
        d = {v, v} >> k;
        return d[63:0];
    endfunction

    function automatic state_t model_perm(input state_t s, input int n);
        state_t     x;
        state_t     y;
        logic [4:0] col;
        logic [4:0] o;
        x = s;
        y = '0;
        for (int r = 12 - n; r < 12; r++) begin
            x[2][7:0] = x[2][7:0] ^ 8'(240 - 15 * r);
            for (int b = 0; b < 64; b++) begin
                col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
                o   = sbox_tbl[col];
                y[0][b] = o[4];
                y[1][b] = o[3];
                y[2][b] = o[2];
                y[3][b] = o[1];
                y[4][b] = o[0];
            end
            x[0] = y[0] ^ rotr(y[0], 19) ^ rotr(y[0], 28);
            x[1] = y[1] ^ rotr(y[1], 61) ^ rotr(y[1], 39);
            x[2] = y[2] ^ rotr(y[2], 1)  ^ rotr(y[2], 6);
            x[3] = y[3] ^ rotr(y[3], 10) ^ rotr(y[3], 17);
            x[4] = y[4] ^ rotr(y[4], 7)  ^ rotr(y[4], 41);
        end
        return x;
    endfunction

    typedef struct {
        string  name;
        state_t exp;
        int     n;
        int     accept;
    } sb_entry_t;

    sb_entry_t sb[$];

    // Monitor: samples on the falling edge, away from the active edge.
    int busy_cnt  = 0;
    bit prev_done = 1'b0;
    initial begin
        sb_entry_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_n_i) begin
                busy_cnt  = 0;
                prev_done = 1'b0;
            end else begin
                if (busy_o) busy_cnt++;
                if (done_o) begin
                    check("done_single_cycle", prev_done, 0);
                    check("busy_low_at_done", busy_o, 0);
                    if (sb.size() == 0) begin
                        check("done_without_request", sb.size(), 1);
                    end else begin
                        e = sb.pop_front();
                        check({e.name, "_state"}, state_o, e.exp);
                        check({e.name, "_latency"}, cyc - e.accept, e.n);
                        check({e.name, "_busy_cycles"}, busy_cnt, e.n);
                    end
                    busy_cnt = 0;
                end
                prev_done = done_o;
            end
        end
    end

    // Issue one request; optionally register the expectation with the scoreboard.
    task automatic issue(input string name, input state_t s, input logic [3:0] rnds,
                         input int exp_n, input state_t exp_state, input bit track);
        int waited;
        sb_entry_t e;
        waited = 0;
        @(negedge clk_i);
        while (!ready_o && waited < 100) begin
            @(negedge clk_i);
            waited++;
        end
        check({name, "_ready"}, ready_o, 1);
        state_i  = s;
        rounds_i = rnds;
        start_i  = 1'b1;
        @(posedge clk_i);
        #1;
        start_i  = 1'b0;
        // Post-acceptance changes to the inputs must not reach the result.
        state_i  = {5{64'hA5A5_5A5A_C3C3_3C3C}};
        rounds_i = 4'd3;
        if (track) begin
            e.name   = name;
            e.exp    = exp_state;
            e.n      = exp_n;
            e.accept = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_state"}, state_o, '0);
        check({name, "_busy"},  busy_o,  0);
        check({name, "_done"},  done_o,  0);
        check({name, "_ready"}, ready_o, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    state_t zero_st, one_rnd_exp, iv_st, alt_st;
    int     drain;

    initial begin
        rst_n_i  = 1'b0;
        start_i  = 1'b0;
        rounds_i = '0;
        state_i  = '0;

        zero_st = '0;

        // One round (r = 11, c = 0x4B) on the all-zero state, derived by hand.
        one_rnd_exp    = '0;
        one_rnd_exp[0] = 64'h0009_64B0_0000_004B;
        one_rnd_exp[1] = 64'h0000_0000_9600_0213;
        one_rnd_exp[2] = 64'h53FF_FFFF_FFFF_FF90;
        one_rnd_exp[3] = 64'h12E5_8000_0000_004B;
        one_rnd_exp[4] = 64'h0000_0000_0000_0000;

        // Ascon-128 initial state: IV, key 00..0f, nonce 10..1f
        iv_st[0] = 64'h8040_0c06_0000_0000;
        iv_st[1] = 64'h0001_0203_0405_0607;
        iv_st[2] = 64'h0809_0a0b_0c0d_0e0f;
        iv_st[3] = 64'h1011_1213_1415_1617;
        iv_st[4] = 64'h1819_1a1b_1c1d_1e1f;

        alt_st[0] = 64'hFEDC_BA98_7654_3210;
        alt_st[1] = 64'h0123_4567_89AB_CDEF;
        alt_st[2] = 64'hFFFF_0000_FFFF_0000;
        alt_st[3] = 64'h0000_0000_0000_0001;
        alt_st[4] = 64'h8000_0000_0000_0000;

        #12;
        check_reset_outputs("reset");
        @(negedge clk_i);
        rst_n_i = 1'b1;

        issue("one_round_zero", zero_st, 4'd1,  1,  one_rnd_exp, 1'b1);
        issue("iv_12",          iv_st,   4'd12, 12, model_perm(iv_st, 12), 1'b1);
        issue("iv_6",           iv_st,   4'd6,  6,  model_perm(iv_st, 6),  1'b1);
        issue("iv_8",           iv_st,   4'd8,  8,  model_perm(iv_st, 8),  1'b1);
        issue("zero_rounds",    iv_st,   4'd0,  0,  iv_st,                 1'b1);
        issue("clamp_15",       iv_st,   4'd15, 12, model_perm(iv_st, 12), 1'b1);

        // A start while running must be ignored and not queued.
        issue("ignored_start",  alt_st,  4'd12, 12, model_perm(alt_st, 12), 1'b1);
        repeat (3) @(negedge clk_i);
        check("not_ready_in_run", ready_o, 0);
        state_i  = zero_st;
        rounds_i = 4'd1;
        start_i  = 1'b1;
        @(negedge clk_i);
        start_i  = 1'b0;

        // Waits through done_o, then starts in the first idle cycle.
        issue("back_to_back",   alt_st,  4'd6,  6,  model_perm(alt_st, 6), 1'b1);

        // Reset in the middle of round 5 of 12: no done pulse may follow.
        issue("aborted",        iv_st,   4'd12, 12, iv_st, 1'b0);
        repeat (4) @(posedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        check_reset_outputs("reset_mid_run");
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("no_done_after_abort", done_o, 0);

        issue("after_reset_12", iv_st,   4'd12, 12, model_perm(iv_st, 12), 1'b1);

        drain = 0;
        while (sb.size() != 0 && drain < 200) begin
            @(negedge clk_i);
            drain++;
        end
        repeat (3) @(negedge clk_i);
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
